stt_phy_freelist: RTL and testbench

- Physical-register free list feeding the STT rename stage.
- Each cycle it presents NUM_DECODE free physical registers on phyreg_flatten for the rename/age block to consume.
- Registers are reclaimed from commit, and speculatively allocated registers are returned on a squash.
- It is the sole allocator of the NUM_PHY-NUM_ARCH non-architectural registers and arbitrates between allocate, free and flush in the same cycle.

---
 rtl/stt_phy_freelist.sv | 140 ++++++++++++++
 tb/tb_stt_phy_freelist.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stt_phy_freelist.sv
// Circular free list of non-architectural physical registers for the STT rename stage.
// Define STT_FREELIST_CHECK_EN to add the sticky fl_error output and its illegal-use checks.
module stt_phy_freelist #(
    parameter  int NUM_DECODE = 10,
    parameter  int NUM_ARCH   = 31,
    parameter  int NUM_PHY    = 380,
    parameter  int PHY_WIDTH  = 9,
    localparam int CAP        = NUM_PHY - NUM_ARCH,
    localparam int PTR_WIDTH  = $clog2(CAP),
    localparam int CNT_WIDTH  = $clog2(CAP + 1)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            alloc_en,
    input  logic [3:0]                      alloc_cnt,
    output logic                            alloc_ready,
    output logic [PHY_WIDTH*NUM_DECODE-1:0] phyreg_flatten,
    input  logic [NUM_DECODE-1:0]           free_valid,
    input  logic [PHY_WIDTH*NUM_DECODE-1:0] free_flatten,
    input  logic                            flush,
    input  logic [CNT_WIDTH-1:0]            flush_cnt,
    output logic [CNT_WIDTH-1:0]            free_count
`ifdef STT_FREELIST_CHECK_EN
    ,
    output logic                            fl_error
`endif
);

    localparam int SW = PTR_WIDTH + 2;
    typedef logic [SW-1:0] sum_t;

    logic [PHY_WIDTH-1:0] fl_q [CAP];
    logic [PHY_WIDTH-1:0] fl_d [CAP];
    logic [PTR_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic [CNT_WIDTH-1:0] pop;
    logic                 fire;

    // CAP is not a power of two, so pointers wrap by compare-and-subtract.
    function automatic logic [PTR_WIDTH-1:0] wrap_add(input logic [PTR_WIDTH-1:0] p,
                                                      input logic [CNT_WIDTH-1:0] n);
        sum_t s;
        s = sum_t'(p) + sum_t'(n);
        if (s >= sum_t'(CAP)) s = s - sum_t'(CAP);
        return s[PTR_WIDTH-1:0];
    endfunction

    function automatic logic [PTR_WIDTH-1:0] wrap_sub(input logic [PTR_WIDTH-1:0] p,
                                                      input logic [CNT_WIDTH-1:0] n);
        sum_t s;
        if (sum_t'(p) >= sum_t'(n)) s = sum_t'(p) - sum_t'(n);
        else                        s = sum_t'(p) + sum_t'(CAP) - sum_t'(n);
        return s[PTR_WIDTH-1:0];
    endfunction

    function automatic logic [PHY_WIDTH-1:0] free_reg(input int unsigned k);
        return free_flatten[PHY_WIDTH*(NUM_DECODE-1-k) +: PHY_WIDTH];
    endfunction

    assign alloc_ready = (count_q >= CNT_WIDTH'(NUM_DECODE));
    assign fire        = alloc_en & alloc_ready & ~flush;
    assign free_count  = count_q;

    always_comb begin
        phyreg_flatten = '0;
        for (int unsigned k = 0; k < NUM_DECODE; k++) begin
            phyreg_flatten[PHY_WIDTH*(NUM_DECODE-1-k) +: PHY_WIDTH] =
                fl_q[wrap_add(head_q, CNT_WIDTH'(k))];
        end
    end

    // Valid free slots are packed in slot order starting at tail.
    always_comb begin
        fl_d = fl_q;
        pop  = '0;
        for (int unsigned k = 0; k < NUM_DECODE; k++) begin
            if (free_valid[k]) begin
                fl_d[wrap_add(tail_q, pop)] = free_reg(k);
                pop = pop + CNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        tail_d = wrap_add(tail_q, pop);
        if (flush)     head_d = wrap_sub(head_q, flush_cnt);
        else if (fire) head_d = wrap_add(head_q, CNT_WIDTH'(alloc_cnt));
        else           head_d = head_q;
        count_d = count_q + pop
                + (flush ? flush_cnt : '0)
                - (fire ? CNT_WIDTH'(alloc_cnt) : '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < CAP; i++) fl_q[i] <= PHY_WIDTH'(NUM_ARCH + i);
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= CNT_WIDTH'(CAP);
        end else begin
            fl_q    <= fl_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

`ifdef STT_FREELIST_CHECK_EN
    localparam int WW = CNT_WIDTH + 2;
    typedef logic [WW-1:0] wide_t;

    logic  fl_error_q, fl_error_d;
    wide_t count_wide;
    logic  bad_free;

    // Wide sum so that overflow past CAP or underflow both read as > CAP.
    always_comb begin
        count_wide = wide_t'(count_q) + wide_t'(pop)
                   + (flush ? wide_t'(flush_cnt) : '0)
                   - (fire ? wide_t'(alloc_cnt) : '0);
        bad_free = 1'b0;
        for (int unsigned k = 0; k < NUM_DECODE; k++) begin
            if (free_valid[k] && (free_reg(k) < PHY_WIDTH'(NUM_ARCH))) bad_free = 1'b1;
        end
        fl_error_d = fl_error_q
                   | (count_wide > wide_t'(CAP))
                   | (fire & (alloc_cnt > 4'(NUM_DECODE)))
                   | bad_free
                   | (flush & ((wide_t'(flush_cnt) + wide_t'(count_q)) > wide_t'(CAP)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) fl_error_q <= 1'b0;
        else     fl_error_q <= fl_error_d;
    end

    assign fl_error = fl_error_q;
`endif

endmodule

// File: tb/tb_stt_phy_freelist.sv
// Randomized + directed bench for stt_phy_freelist against an array/modulo reference model.
module tb_stt_phy_freelist;

    localparam int ND  = 10;
    localparam int NA  = 31;
    localparam int NP  = 380;
    localparam int PW  = 9;
    localparam int CAP = NP - NA;
    localparam int CW  = $clog2(CAP + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             alloc_en;
    logic [3:0]       alloc_cnt;
    logic             alloc_ready;
    logic [PW*ND-1:0] phyreg_flatten;
    logic [ND-1:0]    free_valid;
    logic [PW*ND-1:0] free_flatten;
    logic             flush;
    logic [CW-1:0]    flush_cnt;
    logic [CW-1:0]    free_count;
`ifdef STT_FREELIST_CHECK_EN
    logic             fl_error;
`endif

    stt_phy_freelist #(
        .NUM_DECODE(ND),
        .NUM_ARCH  (NA),
        .NUM_PHY   (NP),
        .PHY_WIDTH (PW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .alloc_en      (alloc_en),
        .alloc_cnt     (alloc_cnt),
        .alloc_ready   (alloc_ready),
        .phyreg_flatten(phyreg_flatten),
        .free_valid    (free_valid),
        .free_flatten  (free_flatten),
        .flush         (flush),
        .flush_cnt     (flush_cnt),
        .free_count    (free_count)
`ifdef STT_FREELIST_CHECK_EN
        ,
        .fl_error      (fl_error)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int m_fl [CAP];
    int m_head, m_tail, m_count;
    bit cmp_on = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int slot(input int k);
        return int'(phyreg_flatten[PW*(ND-1-k) +: PW]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < CAP; i++) m_fl[i] = NA + i;
        m_head  = 0;
        m_tail  = 0;
        m_count = CAP;
    endtask

    task automatic model_step();
        int regs[$];
        bit fire;
        for (int k = 0; k < ND; k++)
            if (free_valid[k]) regs.push_back(int'(free_flatten[PW*(ND-1-k) +: PW]));
        fire = alloc_en && (m_count >= ND) && !flush;
        foreach (regs[j]) m_fl[(m_tail + j) % CAP] = regs[j];
        m_tail = (m_tail + regs.size()) % CAP;
        if (flush)     m_head = (m_head - int'(flush_cnt) + CAP) % CAP;
        else if (fire) m_head = (m_head + int'(alloc_cnt)) % CAP;
        m_count = m_count + regs.size()
                + (flush ? int'(flush_cnt) : 0)
                - (fire ? int'(alloc_cnt) : 0);
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("free_count", int'(free_count), m_count);
            chk("alloc_ready", int'(alloc_ready), (m_count >= ND) ? 1 : 0);
            for (int k = 0; k < ND; k++) begin
                if (k < m_count) begin
                    checks++;
                    if ($isunknown(phyreg_flatten[PW*(ND-1-k) +: PW]) ||
                        slot(k) != m_fl[(m_head + k) % CAP]) begin
                        errors++;
                        $display("FAIL slot%0d actual=%0d expected=%0d", k, slot(k),
                                 m_fl[(m_head + k) % CAP]);
                    end
                end
            end
        end
    end

    task automatic idle();
        alloc_en     = 1'b0;
        alloc_cnt    = '0;
        free_valid   = '0;
        free_flatten = '0;
        flush        = 1'b0;
        flush_cnt    = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (!rst) model_step();
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic set_free(input int k, input int r);
        free_valid[k] = 1'b1;
        free_flatten[PW*(ND-1-k) +: PW] = PW'(r);
    endtask

    task automatic do_alloc(input int n, input int times);
        for (int t = 0; t < times; t++) begin
            alloc_en  = 1'b1;
            alloc_cnt = 4'(n);
            tick();
        end
        idle();
    endtask

    initial begin
        int room, nfree, fmax, fcnt;
        idle();
        rst = 1'b1;
        model_reset();
        cmp_on = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset image
        for (int k = 0; k < ND; k++) chk($sformatf("reset_slot%0d", k), slot(k), 31 + k);
        chk("reset_ready", int'(alloc_ready), 1);
        chk("reset_count", int'(free_count), 349);

        // Three full-width allocations
        do_alloc(10, 3);
        for (int k = 0; k < ND; k++) chk($sformatf("alloc30_slot%0d", k), slot(k), 61 + k);
        chk("alloc30_count", int'(free_count), 319);

        // Partial allocations
        do_reset();
        do_alloc(4, 1);
        for (int k = 0; k < ND; k++) chk($sformatf("alloc4_slot%0d", k), slot(k), 35 + k);
        do_alloc(6, 1);
        for (int k = 0; k < ND; k++) chk($sformatf("alloc6_slot%0d", k), slot(k), 41 + k);
        chk("alloc6_count", int'(free_count), 339);

        // Drain to 9 (head=340), stall, then refill across the wrap point
        do_alloc(10, 33);
        chk("drain_count", int'(free_count), 9);
        chk("drain_ready", int'(alloc_ready), 0);
        do_alloc(10, 1);
        chk("stall_count", int'(free_count), 9);
        set_free(0, 5);
        set_free(9, 7);
        tick();
        idle();
        chk("free2_count", int'(free_count), 11);
        chk("free2_ready", int'(alloc_ready), 1);
        chk("free2_slot9", slot(9), 5);
        for (int k = 0; k < 8; k++) set_free(k, 31 + k);
        tick();
        idle();
        chk("free8_count", int'(free_count), 19);
        // fl[0..9] = 5,7,31..38; head 340+10 wraps to 1
        do_alloc(10, 1);
        chk("wrap_count", int'(free_count), 9);
        chk("wrap_slot0", slot(0), 7);
        chk("wrap_slot8", slot(8), 38);

        // Flush + alloc + free in one cycle after a drain of 20 and an alloc of 10
        do_reset();
        do_alloc(10, 3);
        flush     = 1'b1;
        flush_cnt = CW'(10);
        alloc_en  = 1'b1;
        alloc_cnt = 4'(10);
        set_free(3, 41);
        set_free(6, 42);
        tick();
        idle();
        chk("flush_count", int'(free_count), 331);
        for (int k = 0; k < ND; k++) chk($sformatf("flush_slot%0d", k), slot(k), 51 + k);

        // Randomized legal traffic, with an asynchronous reset in the middle
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c == 1700) begin
                alloc_en  = 1'b1;
                alloc_cnt = 4'(10);
                #2;
                rst = 1'b1;
                model_reset();
                #1;
                idle();
                @(posedge clk);
                #1;
                rst = 1'b0;
            end
            idle();
            alloc_en  = ($urandom_range(0, 3) != 0);
            alloc_cnt = 4'($urandom_range(0, ND));
            room  = CAP - m_count;
            nfree = 0;
            if ($urandom_range(0, 3) == 0 || (c > 800 && c < 1500)) begin
                for (int k = 0; k < ND; k++) begin
                    if ($urandom_range(0, 1) == 1 && nfree < room) begin
                        set_free(k, $urandom_range(NA, NP - 1));
                        nfree++;
                    end
                end
            end
            if ($urandom_range(0, 9) == 0) begin
                fmax = room - nfree;
                if (fmax > 20) fmax = 20;
                fcnt = $urandom_range(0, fmax);
                flush     = 1'b1;
                flush_cnt = CW'(fcnt);
            end
            tick();
        end
        idle();
        tick();

`ifdef STT_FREELIST_CHECK_EN
        chk("fl_error", int'(fl_error), 0);
`endif

        cmp_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
